ringosc_meas_ctrl: RTL

RINGOSC_MEAS_CTRL -- requirements
Module: ringosc_meas_ctrl

---
 rtl/ringosc_meas_pkg.sv | 18 +
 rtl/ringosc_sync.sv | 30 +++
 rtl/ringosc_meas_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ringosc_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement controller.
//   state_t         : controller FSM states
//   *_DEF           : default values for the GATE_W, CLR_CYC and SETTLE_CYC parameters
package ringosc_meas_pkg;

    localparam int GATE_W_DEF     = 16;
    localparam int CLR_CYC_DEF    = 2;
    localparam int SETTLE_CYC_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ringosc_sync.sv
// Two-flop synchronizer for the ring-oscillator count bus.
// Synchronizing the whole bus at once is safe here because the controller
// only uses the output after the oscillator has been stopped long enough for
// the count to be frozen.
//   clk     : system clock
//   reset_i : synchronous active-high reset, clears both stages
//   d       : asynchronous input bus
//   q       : synchronized output bus
module ringosc_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: clears the oscillator counter,
// lets the oscillator run for a programmed window, stops it, waits for the
// frozen count to cross into clk_sys, then presents the captured count until
// acknowledged.
//
// state  | meaning
// IDLE   | oscillator stopped, waiting for start_i
// CLEAR  | oscillator counter held in reset for CLR_CYC cycles
// RUN    | oscillator running for the latched gate length (0 acts as 1)
// SETTLE | oscillator stopped SETTLE_CYC cycles; capture on the last one
// DONE   | result_o valid until ack_i
//
// Ports:
//   clk, reset_i (sync, active-high), start_i, gate_len_i[GATE_W], shift_cfg_i[6],
//   osc_cnt_i[8] (async), ack_i, cont_i (only with RINGOSC_MEAS_CONT_EN),
//   osc_reset_o, osc_stop_o, osc_shift_o[6], busy_o, valid_o, result_o[8]
// Build option: define RINGOSC_MEAS_CONT_EN to add cont_i, which chains a new
// measurement directly from DONE with the same gate length and shift.
// All outputs are registered and reflect the current state.
module ringosc_meas_ctrl
    import ringosc_meas_pkg::*;
#(
    parameter int GATE_W     = GATE_W_DEF,
    parameter int CLR_CYC    = CLR_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_len_i,
    input  logic [5:0]        shift_cfg_i,
    input  logic [7:0]        osc_cnt_i,
    input  logic              ack_i,
`ifdef RINGOSC_MEAS_CONT_EN
    input  logic              cont_i,
`endif
    output logic              osc_reset_o,
    output logic              osc_stop_o,
    output logic [5:0]        osc_shift_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [7:0]        result_o
);

    state_t            state, state_nxt;
    logic [GATE_W-1:0] cnt, cnt_nxt;
    logic [GATE_W-1:0] gate_len_q;
    logic              latch_cfg;
    logic              capture;
    logic [7:0]        osc_cnt_sync;

    ringosc_sync #(.W(8)) u_sync (
        .clk     (clk),
        .reset_i (reset_i),
        .d       (osc_cnt_i),
        .q       (osc_cnt_sync)
    );

    // Down-counter is loaded with (duration - 1) on entry to each timed state;
    // the state exits when it reaches zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
        latch_cfg = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = GATE_W'(CLR_CYC - 1);
                    latch_cfg = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = (gate_len_q == '0) ? '0 : gate_len_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = GATE_W'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    capture   = 1'b1;
                end
            end
            ST_DONE: begin
                if (ack_i) begin
`ifdef RINGOSC_MEAS_CONT_EN
                    if (cont_i) begin
                        state_nxt = ST_CLEAR;
                        cnt_nxt   = GATE_W'(CLR_CYC - 1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            gate_len_q  <= '0;
            osc_shift_o <= '0;
            osc_reset_o <= 1'b0;
            osc_stop_o  <= 1'b1;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            result_o    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            if (latch_cfg) begin
                gate_len_q  <= gate_len_i;
                osc_shift_o <= shift_cfg_i;
            end
            if (capture) begin
                result_o <= osc_cnt_sync;
            end
            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            osc_reset_o <= (state_nxt == ST_CLEAR);
            osc_stop_o  <= (state_nxt != ST_RUN);
            busy_o      <= (state_nxt == ST_CLEAR) || (state_nxt == ST_RUN) ||
                           (state_nxt == ST_SETTLE);
            valid_o     <= (state_nxt == ST_DONE);
        end
    end

endmodule
